// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame controller for the render path (clk_render domain).
// Runs SWAP -> KICK -> FEED -> DRAIN per accepted frame_start, gates the
// feeder->renderer triangle channel during FEED and tags its first beat as the
// camera packet. Also counts dropped frames, measures frame length and aborts
// hung frames with a watchdog.
// Ports:
//   clk_render, rst_render (async, active-high)
//   frame_start, renderer_busy, feeder_busy        : control inputs
//   tri_in_valid/tri_in_ready                      : feeder side handshake
//   tri_out_valid/tri_out_ready                    : renderer side handshake
//   camera_valid, model_valid                      : beat classification
//   fb_swap, feeder_begin                          : state-decoded pulses
//   frame_done, frame_dropped, watchdog_trip       : registered event pulses
//   drop_count, last_frame_cycles, state_dbg       : status / debug
module frame_sequencer #(
  parameter int WATCHDOG_CYCLES = 2_000_000,
  parameter int DROP_CNT_W      = 16,
  parameter int CYC_CNT_W       = 24
) (
  input  logic                  clk_render,
  input  logic                  rst_render,
  input  logic                  frame_start,
  input  logic                  renderer_busy,
  input  logic                  feeder_busy,
  input  logic                  tri_in_valid,
  output logic                  tri_in_ready,
  output logic                  tri_out_valid,
  input  logic                  tri_out_ready,
  output logic                  camera_valid,
  output logic                  model_valid,
  output logic                  fb_swap,
  output logic                  feeder_begin,
  output logic                  frame_done,
  output logic                  frame_dropped,
  output logic                  watchdog_trip,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic [CYC_CNT_W-1:0]  last_frame_cycles,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SWAP  = 3'd1;
  localparam logic [2:0] ST_KICK  = 3'd2;
  localparam logic [2:0] ST_FEED  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [CYC_CNT_W-1:0]  CYC_MAX  = '1;
  localparam logic [CYC_CNT_W-1:0]  CYC_ONE  = CYC_CNT_W'(1);
  localparam logic [CYC_CNT_W-1:0]  WD_LIMIT = CYC_CNT_W'(WATCHDOG_CYCLES);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);
  // Empty scene: FEED cycles without any feeder activity before giving up.
  localparam logic [2:0]            EMPTY_LAST = 3'd3;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic                 first_pending;
  logic                 seen_busy;
  logic [2:0]           empty_cnt;
  logic [CYC_CNT_W-1:0] cyc_cnt;

  logic in_feed;
  logic handshake;
  logic accept;
  logic drop;
  logic wd_expire;
  logic feed_exit;
  logic drain_exit;

  // Channel gating: zero-latency, open only in FEED.
  assign in_feed       = (state == ST_FEED);
  assign tri_out_valid = tri_in_valid && in_feed;
  assign tri_in_ready  = tri_out_ready && in_feed;
  assign camera_valid  = tri_out_valid && first_pending;
  assign model_valid   = tri_out_valid && !first_pending;
  assign handshake     = tri_out_valid && tri_out_ready;

  assign fb_swap      = (state == ST_SWAP);
  assign feeder_begin = (state == ST_KICK);
  assign state_dbg    = state;

  assign accept    = (state == ST_IDLE) && frame_start && !renderer_busy;
  assign drop      = frame_start && !accept;
  // cyc_cnt equals the 1-based index of the current frame cycle.
  assign wd_expire = (state != ST_IDLE) && (cyc_cnt >= WD_LIMIT);

  // seen_busy is the registered flag, so feeder activity in the current cycle
  // only affects the exit decision from the next cycle onward.
  assign feed_exit = (seen_busy && !feeder_busy && !tri_in_valid) ||
                     (!seen_busy && (empty_cnt == EMPTY_LAST));

  // Watchdog takes priority over a normal completion in the same cycle.
  assign drain_exit = (state == ST_DRAIN) && !renderer_busy && !wd_expire;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SWAP;
      ST_SWAP:  state_nxt = ST_KICK;
      ST_KICK:  state_nxt = ST_FEED;
      ST_FEED:  if (feed_exit) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!renderer_busy) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (wd_expire) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render) begin
      state             <= ST_IDLE;
      first_pending     <= 1'b0;
      seen_busy         <= 1'b0;
      empty_cnt         <= 3'd0;
      cyc_cnt           <= '0;
      frame_done        <= 1'b0;
      frame_dropped     <= 1'b0;
      watchdog_trip     <= 1'b0;
      drop_count        <= '0;
      last_frame_cycles <= '0;
    end else begin
      state         <= state_nxt;
      frame_done    <= drain_exit;
      frame_dropped <= drop;
      watchdog_trip <= wd_expire;

      if (drop && (drop_count != DROP_MAX)) drop_count <= drop_count + DROP_ONE;
      if (drain_exit) last_frame_cycles <= cyc_cnt;

      // Loading 1 on accept makes the SWAP cycle count as frame cycle 1.
      if (accept) begin
        cyc_cnt <= CYC_ONE;
      end else if ((state != ST_IDLE) && (cyc_cnt != CYC_MAX)) begin
        cyc_cnt <= cyc_cnt + CYC_ONE;
      end

      if (wd_expire) begin
        first_pending <= 1'b0;
      end else if (state == ST_SWAP) begin
        first_pending <= 1'b1;
      end else if (handshake) begin
        first_pending <= 1'b0;
      end

      if (state == ST_SWAP) begin
        seen_busy <= 1'b0;
      end else if (in_feed && feeder_busy) begin
        seen_busy <= 1'b1;
      end

      if (state == ST_KICK) begin
        empty_cnt <= 3'd0;
      end else if (in_feed && !seen_busy && (empty_cnt != 3'd7)) begin
        empty_cnt <= empty_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized bench for frame_sequencer against a
// frame-age based reference model; every output is compared every cycle.
module tb_frame_sequencer;
  localparam int WD     = 50;
  localparam int DROP_W = 4;
  localparam int CYC_W  = 24;
  localparam int DROP_SAT = (1 << DROP_W) - 1;

  logic              clk_render = 1'b0;
  logic              rst_render = 1'b1;
  logic              frame_start = 1'b0;
  logic              renderer_busy = 1'b0;
  logic              feeder_busy = 1'b0;
  logic              tri_in_valid = 1'b0;
  logic              tri_in_ready;
  logic              tri_out_valid;
  logic              tri_out_ready = 1'b0;
  logic              camera_valid;
  logic              model_valid;
  logic              fb_swap;
  logic              feeder_begin;
  logic              frame_done;
  logic              frame_dropped;
  logic              watchdog_trip;
  logic [DROP_W-1:0] drop_count;
  logic [CYC_W-1:0]  last_frame_cycles;
  logic [2:0]        state_dbg;

  always #5 clk_render = ~clk_render;

  frame_sequencer #(
    .WATCHDOG_CYCLES(WD),
    .DROP_CNT_W(DROP_W),
    .CYC_CNT_W(CYC_W)
  ) dut (
    .clk_render(clk_render),
    .rst_render(rst_render),
    .frame_start(frame_start),
    .renderer_busy(renderer_busy),
    .feeder_busy(feeder_busy),
    .tri_in_valid(tri_in_valid),
    .tri_in_ready(tri_in_ready),
    .tri_out_valid(tri_out_valid),
    .tri_out_ready(tri_out_ready),
    .camera_valid(camera_valid),
    .model_valid(model_valid),
    .fb_swap(fb_swap),
    .feeder_begin(feeder_begin),
    .frame_done(frame_done),
    .frame_dropped(frame_dropped),
    .watchdog_trip(watchdog_trip),
    .drop_count(drop_count),
    .last_frame_cycles(last_frame_cycles),
    .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is described by its age (1 = first cycle after
  // acceptance) plus whether the feed window has closed.
  bit m_active, m_drain, m_busy_seen, m_cam_sent;
  int m_age, m_feed_n;
  bit m_done, m_drop, m_wd;
  int m_drops, m_last;
  int n_wd = 0, n_done7 = 0, n_cam = 0, n_model = 0, n_sat = 0;

  function automatic int m_phase();
    if (!m_active) return 0;
    if (m_age == 1) return 1;
    if (m_age == 2) return 2;
    if (!m_drain) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_active = 0; m_drain = 0; m_busy_seen = 0; m_cam_sent = 0;
    m_age = 0; m_feed_n = 0; m_done = 0; m_drop = 0; m_wd = 0;
    m_drops = 0; m_last = 0;
  endtask

  task automatic model_step(input bit fs, input bit rb, input bit fb, input bit tiv, input bit tor);
    bit feeding, accept, wd;
    feeding = (m_phase() == 3);
    accept  = !m_active && fs && !rb;
    wd      = m_active && (m_age >= WD);
    m_drop  = fs && !accept;
    if (m_drop && m_drops < DROP_SAT) m_drops++;
    if (m_drops == DROP_SAT) n_sat++;
    m_wd   = wd;
    m_done = 0;
    if (feeding && tiv && tor) begin
      if (m_cam_sent) n_model++; else n_cam++;
    end
    if (wd) begin
      m_active = 0;
      n_wd++;
    end else if (accept) begin
      m_active = 1; m_age = 1; m_drain = 0;
      m_busy_seen = 0; m_feed_n = 0; m_cam_sent = 0;
    end else if (m_active) begin
      if (feeding) begin
        m_feed_n++;
        if ((m_busy_seen && !fb && !tiv) || (!m_busy_seen && m_feed_n == 4)) m_drain = 1;
        if (fb) m_busy_seen = 1;
        if (tiv && tor) m_cam_sent = 1;
        m_age++;
      end else if (m_drain && !rb) begin
        m_active = 0; m_done = 1; m_last = m_age;
        if (m_age == 7) n_done7++;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic check_all(input bit tiv, input bit tor);
    int ph;
    bit feeding;
    ph = m_phase();
    feeding = (ph == 3);
    check_eq("tri_out_valid", 32'(tri_out_valid), 32'(feeding && tiv));
    check_eq("tri_in_ready", 32'(tri_in_ready), 32'(feeding && tor));
    check_eq("camera_valid", 32'(camera_valid), 32'(feeding && tiv && !m_cam_sent));
    check_eq("model_valid", 32'(model_valid), 32'(feeding && tiv && m_cam_sent));
    check_eq("fb_swap", 32'(fb_swap), 32'(ph == 1));
    check_eq("feeder_begin", 32'(feeder_begin), 32'(ph == 2));
    check_eq("state_dbg", 32'(state_dbg), 32'(ph));
    check_eq("frame_done", 32'(frame_done), 32'(m_done));
    check_eq("frame_dropped", 32'(frame_dropped), 32'(m_drop));
    check_eq("watchdog_trip", 32'(watchdog_trip), 32'(m_wd));
    check_eq("drop_count", 32'(drop_count), 32'(m_drops));
    check_eq("last_frame_cycles", 32'(last_frame_cycles), 32'(m_last));
  endtask

  // One clock: drive at the falling edge, compare shortly after, then advance
  // the model across the coming rising edge.
  task automatic cycle(input bit rst, input bit fs, input bit rb, input bit fb,
                       input bit tiv, input bit tor);
    @(negedge clk_render);
    rst_render    = rst;
    frame_start   = fs;
    renderer_busy = rb;
    feeder_busy   = fb;
    tri_in_valid  = tiv;
    tri_out_ready = tor;
    #1;
    if (rst) model_reset();
    check_all(tiv, tor);
    if (!rst) model_step(fs, rb, fb, tiv, tor);
  endtask

  task automatic settle_idle();
    for (int i = 0; i < 200; i++) begin
      if (!m_active) break;
      cycle(0, 0, 0, 0, 0, 1);
    end
    check_eq("settle_idle", 32'(m_phase()), 32'd0);
  endtask

  bit rb_r = 0, fb_r = 0;

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    for (int seg = 0; seg < 40; seg++) begin
      case (seg % 5)
        0: begin  // general traffic
          for (int c = 0; c < 60; c++) begin
            if ($urandom_range(0, 5) == 0) rb_r = !rb_r;
            if ($urandom_range(0, 4) == 0) fb_r = !fb_r;
            cycle(0, $urandom_range(0, 9) == 0, rb_r, fb_r,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
          end
        end
        1: begin  // empty scenes
          for (int c = 0; c < 60; c++)
            cycle(0, $urandom_range(0, 7) == 0, 0, 0, 0, 1);
        end
        2: begin  // renderer hangs after feed -> watchdog, drops while hung
          settle_idle();
          cycle(0, 1, 0, 0, 0, 1);
          for (int c = 0; c < 70; c++)
            cycle(0, $urandom_range(0, 2) == 0, 1, 0, $urandom_range(0, 1) == 1, 1);
          rb_r = 0;
        end
        3: begin  // backpressure in 5-cycle stalls with a mostly-valid feeder
          for (int c = 0; c < 60; c++) begin
            if ($urandom_range(0, 4) == 0) fb_r = !fb_r;
            cycle(0, $urandom_range(0, 7) == 0, 0, fb_r,
                  $urandom_range(0, 7) != 0, ((c / 5) % 2) == 1);
          end
        end
        default: begin  // reset in the middle of FEED
          settle_idle();
          cycle(0, 1, 0, 0, 0, 1);
          cycle(0, 0, 0, 0, 0, 1);
          cycle(0, 0, 0, 0, 0, 1);
          for (int c = 0; c < 3; c++)
            cycle(0, 0, 0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
          for (int c = 0; c < 2; c++)
            cycle(1, $urandom_range(0, 1) == 1, 0, 1, 1, 1);
          fb_r = 0;
          cycle(0, 0, 0, 0, 0, 1);
        end
      endcase
    end

    // Scenario coverage reached by the stimulus.
    check_eq("cov_watchdog", 32'(n_wd > 0), 32'd1);
    check_eq("cov_empty_frame7", 32'(n_done7 > 0), 32'd1);
    check_eq("cov_camera_beat", 32'(n_cam > 0), 32'd1);
    check_eq("cov_model_beat", 32'(n_model > 0), 32'd1);
    check_eq("cov_drop_saturate", 32'(n_sat > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule
